// File: rtl/motor_ramp_seq.sv
// Ramp/coast command sequencer in front of motor_cntrl: slews each wheel toward its target once per tick.
// Define MOTOR_RAMP_ASYM_EN to use DECEL_STEP for steps that shrink |speed|.
module motor_ramp_seq #(
  parameter logic [11:0] RAMP_STEP   = 12'd16,
  parameter int          TICK_DIV    = 1024,
  parameter int          COAST_TICKS = 4,
  parameter logic [11:0] DECEL_STEP  = 12'd32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] cmd_lft,
  input  logic [11:0] cmd_rht,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic        estop,
  output logic [11:0] lft,
  output logic [11:0] rht,
  output logic        at_target
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(COAST_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] COAST_LOAD = CW'(COAST_TICKS);

  typedef enum logic {RUN, COAST} wheel_state_e;

  logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
  logic               tick;
  logic               accept;
  logic signed [11:0] cur_q [2];
  logic signed [11:0] cur_d [2];
  logic signed [11:0] tgt_q [2];
  logic signed [11:0] tgt_d [2];
  logic signed [11:0] cmd_in [2];
  wheel_state_e       state_q [2];
  wheel_state_e       state_d [2];
  logic [CW-1:0]      coast_cnt_q [2];
  logic [CW-1:0]      coast_cnt_d [2];
  logic [12:0]        ramp_res [2];

  // -2048 has no positive counterpart, so it is folded onto -2047
  function automatic logic signed [11:0] clamp_cmd(input logic [11:0] c);
    return (c == 12'h800) ? 12'sh801 : $signed(c);
  endfunction

  // One RUN-state step: returns {enter_coast, next_cur}
  function automatic logic [12:0] ramp_step(input logic signed [11:0] cur,
                                            input logic signed [11:0] tgt);
    logic signed [12:0] cur_x, eff, diff, mag, step_x;
    logic        [11:0] step_v;
    logic signed [11:0] nxt;
    logic               opposite;
    cur_x    = {cur[11], cur};
    opposite = (cur != 12'sd0) && (tgt != 12'sd0) && (cur[11] != tgt[11]);
    eff      = opposite ? 13'sd0 : {tgt[11], tgt};
    diff     = eff - cur_x;
    mag      = diff[12] ? -diff : diff;
    step_v   = RAMP_STEP;
`ifdef MOTOR_RAMP_ASYM_EN
    if ((cur_x > 0 && diff < 0) || (cur_x < 0 && diff > 0))
      step_v = DECEL_STEP;
`endif
    step_x = {1'b0, step_v};
    if (mag <= step_x)
      nxt = eff[11:0];
    else if (diff[12])
      nxt = cur - step_v;
    else
      nxt = cur + step_v;
    return {opposite && (nxt == 12'sd0), nxt};
  endfunction

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  assign cmd_rdy   = ~estop;
  assign accept    = cmd_vld & ~estop;
  assign cmd_in[0] = clamp_cmd(cmd_lft);
  assign cmd_in[1] = clamp_cmd(cmd_rht);

  // Ramp FSMs read tgt_q, so a command landing on a tick edge only affects later ticks
  always_comb begin
    for (int w = 0; w < 2; w++) begin
      cur_d[w]       = cur_q[w];
      tgt_d[w]       = tgt_q[w];
      state_d[w]     = state_q[w];
      coast_cnt_d[w] = coast_cnt_q[w];
      ramp_res[w]    = ramp_step(cur_q[w], tgt_q[w]);
      if (estop) begin
        cur_d[w]       = '0;
        tgt_d[w]       = '0;
        state_d[w]     = COAST;
        coast_cnt_d[w] = COAST_LOAD;
      end else begin
        if (accept)
          tgt_d[w] = cmd_in[w];
        if (tick) begin
          unique case (state_q[w])
            RUN: begin
              cur_d[w] = ramp_res[w][11:0];
              if (ramp_res[w][12]) begin
                state_d[w]     = COAST;
                coast_cnt_d[w] = COAST_LOAD;
              end
            end
            COAST: begin
              cur_d[w]       = '0;
              coast_cnt_d[w] = coast_cnt_q[w] - 1'b1;
              if (coast_cnt_q[w] <= CW'(1)) begin
                state_d[w]     = RUN;
                coast_cnt_d[w] = '0;
              end
            end
            default: state_d[w] = RUN;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      for (int w = 0; w < 2; w++) begin
        cur_q[w]       <= '0;
        tgt_q[w]       <= '0;
        state_q[w]     <= RUN;
        coast_cnt_q[w] <= '0;
      end
    end else begin
      tick_cnt_q <= tick_cnt_d;
      for (int w = 0; w < 2; w++) begin
        cur_q[w]       <= cur_d[w];
        tgt_q[w]       <= tgt_d[w];
        state_q[w]     <= state_d[w];
        coast_cnt_q[w] <= coast_cnt_d[w];
      end
    end
  end

  assign lft       = cur_q[0];
  assign rht       = cur_q[1];
  assign at_target = (state_q[0] == RUN) && (state_q[1] == RUN) &&
                     (cur_q[0] == tgt_q[0]) && (cur_q[1] == tgt_q[1]);

endmodule

// File: tb/tb_motor_ramp_seq.sv
// Directed bench for motor_ramp_seq with TICK_DIV=4 (tick on every 4th edge after reset release).
module tb_motor_ramp_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] cmd_lft, cmd_rht;
  logic        cmd_vld, cmd_rdy, estop;
  logic [11:0] lft, rht;
  logic        at_target;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

`ifdef MOTOR_RAMP_ASYM_EN
  localparam int DEC = 32;
`else
  localparam int DEC = 16;
`endif

  always #5 clk = ~clk;

  motor_ramp_seq #(
    .RAMP_STEP(12'd16), .TICK_DIV(4), .COAST_TICKS(4), .DECEL_STEP(12'd32)
  ) dut (
    .clk(clk), .rst(rst), .cmd_lft(cmd_lft), .cmd_rht(cmd_rht),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .estop(estop),
    .lft(lft), .rht(rht), .at_target(at_target)
  );

  task clk_edge;
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task next_tick;
    do clk_edge(); while (edge_n % 4 != 0);
  endtask

  task do_reset;
    rst = 1'b1; cmd_vld = 1'b0; estop = 1'b0; cmd_lft = '0; cmd_rht = '0;
    clk_edge();
    clk_edge();
    rst = 1'b0;
    edge_n = 0;
  endtask

  task send_cmd(input logic [11:0] l, input logic [11:0] r);
    cmd_lft = l; cmd_rht = r; cmd_vld = 1'b1;
    clk_edge();
    cmd_vld = 1'b0;
  endtask

  task test_reset;
    rst = 1'b1; cmd_vld = 1'b0; estop = 1'b0; cmd_lft = '0; cmd_rht = '0;
    clk_edge();
    checks++; if (lft !== 12'h000 || rht !== 12'h000) begin errors++; $display("[TB] FAIL reset_out: lft=%h rht=%h expected 000/000", lft, rht); end
    do_reset();
    checks++; if (at_target !== 1'b1) begin errors++; $display("[TB] FAIL reset_at_target: got %b expected 1", at_target); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_rdy: got %b expected 1", cmd_rdy); end
  endtask

  task test_ramp_up;
    do_reset();
    send_cmd(12'h100, 12'h100);
    checks++; if (at_target !== 1'b0) begin errors++; $display("[TB] FAIL ramp_accept_at_target: got %b expected 0", at_target); end
    for (int i = 1; i <= 16; i++) begin
      next_tick();
      checks++; if (lft !== 12'(16*i) || rht !== 12'(16*i)) begin errors++; $display("[TB] FAIL ramp_up tick %0d: lft=%h rht=%h expected %h", i, lft, rht, 12'(16*i)); end
      checks++; if (at_target !== (i == 16)) begin errors++; $display("[TB] FAIL ramp_up_at_target tick %0d: got %b expected %b", i, at_target, (i == 16)); end
    end
  endtask

  task test_small_step;
    logic [11:0] exp_l [5];
    exp_l = '{12'h010, 12'h020, 12'h025, 12'h025, 12'h025};
    do_reset();
    send_cmd(12'h025, 12'h000);
    for (int i = 0; i < 5; i++) begin
      next_tick();
      checks++; if (lft !== exp_l[i]) begin errors++; $display("[TB] FAIL small_step tick %0d: got %h expected %h", i, lft, exp_l[i]); end
    end
  endtask

  task test_reversal;
    logic [11:0] exp_l [10];
    exp_l = '{12'h020, 12'h010, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000,
              12'hFF0, 12'hFE0, 12'hFE0};
    do_reset();
    send_cmd(12'h030, 12'h000);
    repeat (3) next_tick();
    checks++; if (lft !== 12'h030) begin errors++; $display("[TB] FAIL reversal_start: got %h expected 030", lft); end
    send_cmd(12'hFE0, 12'h000);
    for (int i = 0; i < 10; i++) begin
      next_tick();
      checks++; if (lft !== exp_l[i]) begin errors++; $display("[TB] FAIL reversal tick %0d: got %h expected %h", i, lft, exp_l[i]); end
    end
    checks++; if (at_target !== 1'b1) begin errors++; $display("[TB] FAIL reversal_at_target: got %b expected 1", at_target); end
  endtask

  task test_estop;
    do_reset();
    send_cmd(12'h080, 12'h000);
    repeat (8) next_tick();
    checks++; if (lft !== 12'h080) begin errors++; $display("[TB] FAIL estop_pre: got %h expected 080", lft); end
    estop = 1'b1; cmd_vld = 1'b1; cmd_lft = 12'h100; cmd_rht = 12'h100;
    #1;
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("[TB] FAIL estop_cmd_rdy: got %b expected 0", cmd_rdy); end
    for (int i = 0; i < 3; i++) begin
      clk_edge();
      checks++; if (lft !== 12'h000 || at_target !== 1'b0 || cmd_rdy !== 1'b0) begin errors++; $display("[TB] FAIL estop_hold cycle %0d: lft=%h at_target=%b cmd_rdy=%b expected 000/0/0", i, lft, at_target, cmd_rdy); end
    end
    estop = 1'b0; cmd_vld = 1'b0;
    #1;
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("[TB] FAIL estop_release_rdy: got %b expected 1", cmd_rdy); end
    for (int i = 1; i <= 6; i++) begin
      next_tick();
      checks++; if (lft !== 12'h000 || rht !== 12'h000) begin errors++; $display("[TB] FAIL estop_coast tick %0d: lft=%h rht=%h expected 000", i, lft, rht); end
      checks++; if (at_target !== (i >= 4)) begin errors++; $display("[TB] FAIL estop_coast_at_target tick %0d: got %b expected %b", i, at_target, (i >= 4)); end
    end
  endtask

  task test_clamp;
    do_reset();
    send_cmd(12'h800, 12'h000);
    repeat (127) next_tick();
    checks++; if (lft !== 12'h810) begin errors++; $display("[TB] FAIL clamp_tick127: got %h expected 810", lft); end
    next_tick();
    checks++; if (lft !== 12'h801 || at_target !== 1'b1) begin errors++; $display("[TB] FAIL clamp_final: lft=%h at_target=%b expected 801/1", lft, at_target); end
    next_tick();
    checks++; if (lft !== 12'h801) begin errors++; $display("[TB] FAIL clamp_hold: got %h expected 801", lft); end
  endtask

  task test_tick_collision;
    do_reset();
    repeat (3) clk_edge();
    send_cmd(12'h100, 12'h000);
    checks++; if (lft !== 12'h000 || at_target !== 1'b0) begin errors++; $display("[TB] FAIL collision_old_tgt: lft=%h at_target=%b expected 000/0", lft, at_target); end
    next_tick();
    checks++; if (lft !== 12'h010) begin errors++; $display("[TB] FAIL collision_next: got %h expected 010", lft); end
  endtask

  task test_back_to_back;
    logic [11:0] exp_r [3];
    exp_r = '{12'hFF0, 12'hFE0, 12'hFD0};
    do_reset();
    send_cmd(12'h100, 12'hFD0);
    for (int i = 0; i < 3; i++) begin
      next_tick();
      checks++; if (lft !== 12'(16*(i+1)) || rht !== exp_r[i]) begin errors++; $display("[TB] FAIL b2b tick %0d: lft=%h rht=%h expected %h/%h", i, lft, rht, 12'(16*(i+1)), exp_r[i]); end
    end
    send_cmd(12'h020, 12'hFD0);
    next_tick();
    checks++; if (lft !== 12'h020 || rht !== 12'hFD0 || at_target !== 1'b1) begin errors++; $display("[TB] FAIL b2b_overwrite: lft=%h rht=%h at_target=%b expected 020/FD0/1", lft, rht, at_target); end
  endtask

  task test_ramp_down;
    do_reset();
    send_cmd(12'h100, 12'h000);
    repeat (16) next_tick();
    send_cmd(12'h000, 12'h000);
    for (int i = 1; i <= 256 / DEC; i++) begin
      next_tick();
      checks++; if (lft !== 12'(256 - DEC*i)) begin errors++; $display("[TB] FAIL ramp_down tick %0d: got %h expected %h", i, lft, 12'(256 - DEC*i)); end
    end
    checks++; if (at_target !== 1'b1) begin errors++; $display("[TB] FAIL ramp_down_at_target: got %b expected 1", at_target); end
  endtask

  task test_async_reset;
    do_reset();
    send_cmd(12'h100, 12'h100);
    repeat (5) next_tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (lft !== 12'h000 || rht !== 12'h000 || at_target !== 1'b1) begin errors++; $display("[TB] FAIL async_reset: lft=%h rht=%h at_target=%b expected 000/000/1", lft, rht, at_target); end
    rst = 1'b0;
    edge_n = 0;
    repeat (2) next_tick();
    checks++; if (lft !== 12'h000) begin errors++; $display("[TB] FAIL async_reset_tgt: got %h expected 000", lft); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_small_step();
    test_reversal();
    test_estop();
    test_clamp();
    test_tick_collision();
    test_back_to_back();
    test_ramp_down();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/motor_ramp_seq.md
Name: motor_ramp_seq

Overview:
Command sequencer that sits in front of motor_cntrl and drives its lft/rht speed inputs.
- Accepts target wheel speeds from the navigation logic through a valid/ready handshake.
- Slews each wheel toward its target in fixed steps, once per PWM-period tick.
- Forces a zero-output coast dead-time before any direction reversal, protecting the H-bridge.
- Provides an emergency-stop path.

Parameters:
RAMP_STEP, 12'd16, magnitude change applied per tick.
TICK_DIV, 1024, clocks per ramp tick (one PWM period).
COAST_TICKS, 4, ticks held at zero before a reversal.
DECEL_STEP, 12'd32, per-tick magnitude decrease; used only with MOTOR_RAMP_ASYM_EN.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
cmd_lft  in  12  target left speed, signed two's complement, positive = forward.
cmd_rht  in  12  target right speed, same format.
cmd_vld  in  1  command valid.
cmd_rdy  out  1  command accepted when cmd_vld & cmd_rdy.
estop  in  1  level-sensitive emergency stop.
lft  out  12  signed speed to motor_cntrl, registered.
rht  out  12  signed speed to motor_cntrl, registered.
at_target  out  1  both wheels in RUN and lft==tgt_lft, rht==tgt_rht.

Behaviour:
- Reset: lft=rht=0; targets=0; tick counter=0; both wheel FSMs=RUN; coast counters=0. Outputs after reset: at_target=1, cmd_rdy=1.
- Tick generation: free-running counter 0..TICK_DIV-1. tick is high for the single cycle when count==TICK_DIV-1; the counter then wraps to 0.
- cmd_rdy = ~estop (combinational).
- Command accept: on a handshake, cmd_lft/cmd_rht latch into tgt_lft/tgt_rht on that edge.
  - Input 12'h800 (-2048) is clamped to 12'h801 (-2047).
  - The new target takes effect at the next tick.
  - A later handshake overwrites the targets at any time, including mid-ramp or during COAST.
- Per-wheel FSM, identical and independent for each wheel, evaluated only on tick:
  - RUN state:
    - Effective target tgt_eff = tgt, except when cur!=0 and sign(tgt) is opposite to sign(cur); then tgt_eff = 0.
    - cur moves toward tgt_eff by min(RAMP_STEP, |tgt_eff-cur|). There is no overshoot and no change when cur==tgt_eff.
    - If this step brings cur to 0 while tgt is nonzero and opposite in sign to the previous cur: enter COAST with coast_cnt=COAST_TICKS.
  - COAST state:
    - Output held at 0; coast_cnt decrements each tick.
    - When the decrement reaches 0, return to RUN. Ramping toward tgt starts on the following tick.
    - COAST always completes, even if a new command removes the reversal.
- Arithmetic: step computation uses 13-bit signed intermediates; the result always lies within [-2047, +2047].
- estop high, on each clock:
  - lft=rht=0 on the next edge; targets cleared to 0.
  - Both FSMs forced to COAST with coast_cnt=COAST_TICKS, reloaded every cycle while estop is high.
  - After estop falls, the coast runs to completion; the wheels then stay at 0 until a new command arrives.
- Simultaneous estop and cmd_vld: estop wins and no handshake occurs.
- Simultaneous command accept and tick: the tick uses the old targets.
- Asynchronous reset mid-ramp or mid-coast returns all state to reset values immediately.

Optional Feature:
MOTOR_RAMP_ASYM_EN:
- Defined: steps that reduce |cur|, including ramps to zero before a reversal, use DECEL_STEP; steps that increase |cur| use RAMP_STEP.
- Undefined: RAMP_STEP is used for all steps and DECEL_STEP is ignored.

Test Plan (TICK_DIV=4, other parameters at default, macro undefined unless stated):
1. Assert rst, then release → lft=rht=0, at_target=1, cmd_rdy=1. Send cmd 0x100/0x100 → lft/rht rise by 0x010 per tick; reach 0x100 after 16 ticks; at_target rises on that edge.
2. From 0, send cmd_lft=0x025 → lft sequence 0x010, 0x020, 0x025, then holds.
3. From lft=0x030, send cmd_lft=0xFE0 (-0x20) → lft sequence 0x020, 0x010, 0x000; held 0 for 4 ticks; then 0xFF0, 0xFE0.
4. At lft=0x080, pulse estop for 3 clocks → lft=0 on the next edge; cmd_rdy=0 while estop is high; after release, coasts 4 ticks and remains 0 with at_target=1.
5. Send cmd_lft=0x800 → tgt clamps to 0x801; lft reaches 0x801 after 128 ticks (final step 15).
6. With MOTOR_RAMP_ASYM_EN defined, from lft=0x100 send cmd 0x000 → lft decreases by 0x020 per tick; reaches 0 after 8 ticks.
